// File: rtl/jelly2_address_burst_pkg.sv
//==============================================================================
// Module      : jelly2_address_burst_pkg
// Description : Shared types and helpers for the address burst combiner.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package jelly2_address_burst_pkg;

  // Combiner control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no burst open
    ST_OPEN  = 2'd1,  // burst accumulating beats
    ST_FLUSH = 2'd2   // one-beat burst held behind an emitted one
  } state_t;

  // Bits needed to count 0..max_len beats
  function automatic int cnt_bits(input int max_len);
    return (max_len < 1) ? 1 : $clog2(max_len + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jelly2_data_ff_pack.sv
//==============================================================================
// Module      : jelly2_data_ff_pack
// Description : Optional valid/ready register slice for a packed data word.
//               S_REGS=0 is a plain wire-through.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module jelly2_data_ff_pack #(
  parameter int DATA_WIDTH = 8,
  parameter int S_REGS     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  if (S_REGS != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    assign s_ready = !valid_q || m_ready;
    assign m_data  = data_q;
    assign m_valid = valid_q;

    // Refill the slice whenever its content is consumed or it is empty
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (cke && s_ready) begin
        data_q  <= s_data;
        valid_q <= s_valid;
      end
    end
  end else begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, reset_n, cke};
    assign s_ready = m_ready;
    assign m_data  = s_data;
    assign m_valid = s_valid;
  end

endmodule

`default_nettype wire

// File: rtl/jelly2_address_burst_combiner.sv
//==============================================================================
// Module      : jelly2_address_burst_combiner
// Description : Merges a stream of per-beat addresses into bursts of
//               contiguous beats, never exceeding MAX_LEN beats and never
//               crossing a BOUNDARY-aligned address.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module jelly2_address_burst_combiner
  import jelly2_address_burst_pkg::*;
#(
  parameter int          N          = 3,
  parameter int          ADDR_WIDTH = 32,
  parameter int          LEN_WIDTH  = 8,
  parameter int          MAX_LEN    = 16,
  parameter int          UNIT_SIZE  = 4,
  parameter int          BOUNDARY   = 4096,
  parameter bit          LEN_OFFSET = 1'b1,
  parameter int          USER_WIDTH = 0,
  parameter int          S_REGS     = 0,
  localparam int         USER_BITS  = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [N-1:0]          s_first,
  input  logic [N-1:0]          s_last,
  input  logic [USER_BITS-1:0]  s_user,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LEN_WIDTH-1:0]  m_len,
  output logic                  m_last,
  output logic [USER_BITS-1:0]  m_user,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int                    CNT_W    = cnt_bits(MAX_LEN);
  localparam int                    DW       = ADDR_WIDTH + 1 + USER_BITS;
  localparam logic [ADDR_WIDTH-1:0] BMASK    = ADDR_WIDTH'(BOUNDARY - 1);
  localparam logic [ADDR_WIDTH-1:0] UNIT     = ADDR_WIDTH'(UNIT_SIZE);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]      CNT_PRE  = CNT_W'(MAX_LEN - 1);
  localparam bit                    ONE_BEAT = (MAX_LEN == 1);

  // Only the outermost last flag matters; first flags are not needed
  logic unused_in;
  assign unused_in = ^{s_first, s_last};

  // Input slice
  logic [DW-1:0]         b_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_last;
  logic [USER_BITS-1:0]  b_user;

  jelly2_data_ff_pack #(
    .DATA_WIDTH (DW),
    .S_REGS     (S_REGS)
  ) u_slice (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .s_data  ({s_addr, s_last[N-1], s_user}),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (b_data),
    .m_valid (b_valid),
    .m_ready (b_ready)
  );

  assign b_addr = b_data[DW-1 -: ADDR_WIDTH];
  assign b_last = b_data[USER_BITS];
  assign b_user = b_data[USER_BITS-1:0];

  // Burst accumulator and output register
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] next_q,  next_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [USER_BITS-1:0]  user_q,  user_d;
  logic                  flast_q, flast_d;

  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [LEN_WIDTH-1:0]  m_len_q;
  logic                  m_last_q;
  logic [USER_BITS-1:0]  m_user_q;
  logic                  m_valid_q;

  logic                  out_free;
  logic                  beat_acc;
  logic                  extend;
  logic                  emit;
  logic [ADDR_WIDTH-1:0] e_addr;
  logic [CNT_W-1:0]      e_cnt;
  logic                  e_last;
  logic [USER_BITS-1:0]  e_user;

  assign out_free = (!m_valid_q || m_ready) && cke;
  assign b_ready  = (state_q != ST_FLUSH) && (!m_valid_q || m_ready);
  assign beat_acc = b_valid && b_ready && cke;
  // next_q tracks start + count*UNIT modulo 2^ADDR_WIDTH, so a wrap to 0
  // also fails the boundary test and breaks the burst
  assign extend   = (b_addr == next_q) && (count_q < CNT_MAX) &&
                    ((b_addr & BMASK) != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      next_q  <= '0;
      count_q <= '0;
      user_q  <= '0;
      flast_q <= 1'b0;
    end else if (cke) begin
      state_q <= state_d;
      start_q <= start_d;
      next_q  <= next_d;
      count_q <= count_d;
      user_q  <= user_d;
      flast_q <= flast_d;
    end
  end

  // Next-state and burst-emission decision
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    next_d  = next_q;
    count_d = count_q;
    user_d  = user_q;
    flast_d = flast_q;
    emit    = 1'b0;
    e_addr  = start_q;
    e_cnt   = count_q;
    e_last  = 1'b0;
    e_user  = user_q;
    unique case (state_q)
      ST_IDLE: begin
        if (beat_acc) begin
          start_d = b_addr;
          next_d  = b_addr + UNIT;
          count_d = CNT_W'(1);
          user_d  = b_user;
          if (b_last || ONE_BEAT) begin
            emit    = 1'b1;
            e_addr  = b_addr;
            e_cnt   = CNT_W'(1);
            e_last  = b_last;
            e_user  = b_user;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_OPEN;
          end
        end
      end
      ST_OPEN: begin
        if (beat_acc) begin
          if (extend) begin
            count_d = count_q + CNT_W'(1);
            next_d  = next_q + UNIT;
            if (b_last || (count_q == CNT_PRE)) begin
              emit    = 1'b1;
              e_cnt   = count_q + CNT_W'(1);
              e_last  = b_last;
              state_d = ST_IDLE;
            end
          end else begin
            // Close the old burst and start a new one at this beat
            emit    = 1'b1;
            start_d = b_addr;
            next_d  = b_addr + UNIT;
            count_d = CNT_W'(1);
            user_d  = b_user;
            flast_d = b_last;
            if (b_last || ONE_BEAT) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          emit    = 1'b1;
          e_last  = flast_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single output register, held until consumed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_addr_q  <= '0;
      m_len_q   <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      m_valid_q <= 1'b0;
    end else if (cke) begin
      if (emit) begin
        m_addr_q  <= e_addr;
        m_len_q   <= LEN_WIDTH'(e_cnt) - LEN_WIDTH'(LEN_OFFSET);
        m_last_q  <= e_last;
        m_user_q  <= e_user;
        m_valid_q <= 1'b1;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_addr  = m_addr_q;
  assign m_len   = m_len_q;
  assign m_last  = m_last_q;
  assign m_user  = m_user_q;
  assign m_valid = m_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_jelly2_address_burst_combiner.sv
//==============================================================================
// Module      : tb_jelly2_address_burst_combiner
// Description : Self-checking bench for jelly2_address_burst_combiner with a
//               burst-list reference model and randomized traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_jelly2_address_burst_combiner;

  localparam int MAXL  = 16;
  localparam int UNITB = 4;
  localparam int BOUND = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cke = 1'b1;
  logic [31:0] s_addr = '0;
  logic [2:0]  s_first = '0;
  logic [2:0]  s_last = '0;
  logic [0:0]  s_user = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic        m_last;
  logic [0:0]  m_user;
  logic        m_valid;
  logic        m_ready = 1'b1;

  jelly2_address_burst_combiner #(
    .N (3), .ADDR_WIDTH (32), .LEN_WIDTH (8), .MAX_LEN (MAXL),
    .UNIT_SIZE (UNITB), .BOUNDARY (BOUND), .LEN_OFFSET (1'b1), .USER_WIDTH (0)
  ) dut (
    .clk (clk), .reset_n (reset_n), .cke (cke),
    .s_addr (s_addr), .s_first (s_first), .s_last (s_last), .s_user (s_user),
    .s_valid (s_valid), .s_ready (s_ready),
    .m_addr (m_addr), .m_len (m_len), .m_last (m_last), .m_user (m_user),
    .m_valid (m_valid), .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: list of expected bursts built from accepted beats
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
    logic [0:0]  user;
  } burst_t;

  burst_t      expq[$];
  logic        mdl_open = 1'b0;
  logic [31:0] mdl_start = '0;
  int          mdl_cnt = 0;
  logic [0:0]  mdl_user = '0;
  int          n_bursts = 0;
  int          n_stall = 0;

  task automatic push_burst(input logic lst);
    burst_t b;
    b.addr = mdl_start;
    b.len  = 8'(mdl_cnt - 1);
    b.last = lst;
    b.user = mdl_user;
    expq.push_back(b);
  endtask

  task automatic model_beat(input logic [31:0] a, input logic lst, input logic [0:0] u);
    if (mdl_open && (a == mdl_start + 32'(mdl_cnt * UNITB)) && (mdl_cnt < MAXL) && (a % BOUND != 0)) begin
      mdl_cnt++;
    end else begin
      if (mdl_open) push_burst(1'b0);
      mdl_start = a;
      mdl_cnt   = 1;
      mdl_user  = u;
      mdl_open  = 1'b1;
    end
    if (lst) begin
      push_burst(1'b1);
      mdl_open = 1'b0;
    end else if (mdl_cnt == MAXL) begin
      push_burst(1'b0);
      mdl_open = 1'b0;
    end
  endtask

  // Monitor: scoreboard outputs, stall rule, feed accepted beats to the model
  always @(negedge clk) begin
    burst_t e;
    if (!reset_n) begin
      mdl_open = 1'b0;
      expq.delete();
    end else begin
      if (m_valid && m_ready && cke) begin
        n_bursts++;
        if (expq.size() == 0) begin
          check_val("extra_burst", {32'h0, m_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check_val("m_addr", 64'(m_addr), 64'(e.addr));
          check_val("m_len",  64'(m_len),  64'(e.len));
          check_val("m_last", 64'(m_last), 64'(e.last));
          check_val("m_user", 64'(m_user), 64'(e.user));
        end
      end
      if (m_valid && !m_ready) check_val("s_ready_stall", 64'(s_ready), 64'd0);
      if (!s_ready) n_stall++;
      if (s_valid && s_ready && cke) model_beat(s_addr, s_last[2], s_user);
    end
  end

  // Background driver for m_ready / cke
  logic rnd_mode = 1'b0;
  int   hold_req = 0;
  int   hold_seen = 0;
  int   hold_left = 0;
  always @(posedge clk) begin
    #1;
    if (hold_req != hold_seen) begin
      hold_seen = hold_req;
      hold_left = 5;
    end
    if (hold_left > 0) begin
      m_ready = 1'b0;
      hold_left--;
    end else if (rnd_mode) begin
      m_ready = ($urandom_range(0, 9) < 7);
    end else begin
      m_ready = 1'b1;
    end
    cke = rnd_mode ? ($urandom_range(0, 9) < 9) : 1'b1;
  end

  // Present one beat and hold it until accepted (called at posedge+1)
  task automatic send(input logic [31:0] a, input logic lst, input logic [0:0] u);
    int t;
    bit done;
    s_addr  = a;
    s_last  = {lst, 2'($urandom)};
    s_first = 3'($urandom);
    s_user  = u;
    s_valid = 1'b1;
    t = 0;
    done = 1'b0;
    while (!done && t < 2000) begin
      @(negedge clk);
      if (s_ready && cke) done = 1'b1;
      t++;
    end
    if (!done) check_val("send_timeout", 64'(t), 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((expq.size() != 0 || m_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val(tag, 64'(expq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int b0;
    int z0;
    logic [31:0] a;
    int r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_m_valid", 64'(m_valid), 64'd0);
    check_val("rst_m_addr",  64'(m_addr),  64'd0);
    check_val("rst_m_len",   64'(m_len),   64'd0);
    check_val("rst_m_last",  64'(m_last),  64'd0);
    check_val("rst_m_user",  64'(m_user),  64'd0);
    check_val("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Eight contiguous beats closed by last
    b0 = n_bursts;
    for (int i = 0; i < 8; i++) send(32'h1000 + 32'(4 * i), (i == 7), 1'b1);
    drain("drain_8beat");
    check_val("bursts_8beat", 64'(n_bursts - b0), 64'd1);

    // Twenty beats split at MAX_LEN
    b0 = n_bursts;
    for (int i = 0; i < 20; i++) send(32'h2000 + 32'(4 * i), (i == 19), 1'(i));
    drain("drain_20beat");
    check_val("bursts_20beat", 64'(n_bursts - b0), 64'd2);

    // 4 KiB boundary crossing
    b0 = n_bursts;
    send(32'h0FF8, 1'b0, 1'b0);
    send(32'h0FFC, 1'b0, 1'b1);
    send(32'h1000, 1'b0, 1'b1);
    send(32'h1004, 1'b1, 1'b0);
    drain("drain_boundary");
    check_val("bursts_boundary", 64'(n_bursts - b0), 64'd2);

    // Discontiguous last beat forces one flush cycle
    b0 = n_bursts;
    z0 = n_stall;
    send(32'h100, 1'b0, 1'b0);
    send(32'h104, 1'b0, 1'b0);
    send(32'h200, 1'b1, 1'b1);
    drain("drain_flush");
    check_val("bursts_flush", 64'(n_bursts - b0), 64'd2);
    check_val("flush_stall_cycles", 64'(n_stall - z0), 64'd1);

    // Address wrap-around
    b0 = n_bursts;
    send(32'hFFFF_FFF8, 1'b0, 1'b0);
    send(32'hFFFF_FFFC, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b1, 1'b1);
    drain("drain_wrap");
    check_val("bursts_wrap", 64'(n_bursts - b0), 64'd2);

    // Output back-pressure for 5 cycles mid-stream
    b0 = n_bursts;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) hold_req++;
      send(32'h3000 + 32'(4 * i), (i % 2 == 1), 1'(i));
    end
    drain("drain_hold");
    check_val("bursts_hold", 64'(n_bursts - b0), 64'd6);

    // Reset with a burst open
    b0 = n_bursts;
    for (int i = 0; i < 3; i++) send(32'h5000 + 32'(4 * i), 1'b0, 1'b1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_open_m_valid", 64'(m_valid), 64'd0);
    check_val("rst_open_m_addr",  64'(m_addr),  64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(32'h1000 + 32'(4 * i), (i == 7), 1'b0);
    drain("drain_after_rst");
    check_val("bursts_after_rst", 64'(n_bursts - b0), 64'd1);

    // Randomized traffic
    rnd_mode = 1'b1;
    a = 32'h0000_8000;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 80)      a = a + 32'd4;
      else if (r < 86) a = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else if (r < 93) a = ($urandom & 32'hFFFF_F000) - 32'd8;
      else             a = $urandom & 32'hFFFF_FFFC;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(a, (i == 299) || ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    drain("drain_random");
    rnd_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
